fft_uart_frame_sender: RTL and testbench

- Upstream feeder for the byte-wide UART transmitter.
- Captures one complete 8-point FFT result frame (complex, fixed-point) in a single cycle.
- Serialises the frame into a byte stream: sync byte, then real/imag words, LSB byte first.
- Drives the transmitter's i_Tx_DV/i_Tx_Data and paces itself on the transmitter's o_Tx_Active/o_Tx_Done.

---
 rtl/fft_uart_pkg.sv | 20 ++
 rtl/fft_uart_frame_sender.sv | 128 ++++++++++++
 tb/tb_fft_uart_frame_sender.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT frame serialiser: FSM encoding, default sync
// byte and the frame length helper.
package fft_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One sync byte followed by every real/imag word of every point.
  function automatic int unsigned total_bytes(input int unsigned n_points,
                                              input int unsigned data_width);
    return 1 + n_points * 2 * (data_width / 8);
  endfunction

endpackage

// File: rtl/fft_uart_frame_sender.sv
// Captures an 8-point complex FFT frame and feeds it byte by byte (sync byte,
// then re0, im0, re1, ... LSB first) to a byte-wide UART transmitter.
module fft_uart_frame_sender
  import fft_uart_pkg::*;
#(
  parameter int unsigned N_POINTS   = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Load,
  input  logic [N_POINTS*2*DATA_WIDTH-1:0] i_Frame,
  input  logic                             i_Tx_Active,
  input  logic                             i_Tx_Done,
  output logic                             o_Tx_DV,
  output logic [7:0]                       o_Tx_Byte,
  output logic                             o_Busy,
  output logic                             o_Frame_Done,
  output logic                             o_Overrun,
  output logic [1:0]                       o_State
);

  localparam int unsigned FRAME_W     = N_POINTS * 2 * DATA_WIDTH;
  localparam int unsigned TOTAL_BYTES = total_bytes(N_POINTS, DATA_WIDTH);
  localparam int unsigned IDX_W       = $clog2(TOTAL_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);

  // Handshake: o_Tx_DV is a single-cycle strobe with o_Tx_Byte held stable
  // under it; a byte is only offered when the transmitter reports neither
  // active nor done, so it is guaranteed to be sitting idle and take it.

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic [IDX_W-1:0]     data_idx;
  logic [7:0]           byte_sel;

  // Words are packed contiguously and sent LSB first, so data byte j sits
  // at bit offset 8*j of the captured frame.
  always_comb begin
    data_idx = idx_q - IDX_W'(1);
    byte_sel = (idx_q == '0) ? SYNC_BYTE : 8'(frame_q >> {data_idx, 3'b000});
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = i_Load & busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Load) begin
          frame_d = i_Frame;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_Tx_Active && !i_Tx_Done) begin
          tx_byte_d = byte_sel;
          tx_dv_d   = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = ST_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // The frame buffer survives reset; only a fresh load overwrites it.
  always_ff @(posedge i_Clock) begin
    frame_q <= frame_d;
  end

  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = frame_done_q;
  assign o_Overrun    = overrun_q;
  assign o_State      = state_q;

endmodule

// File: tb/tb_fft_uart_frame_sender.sv
// Bench for fft_uart_frame_sender: a behavioural UART transmitter plus serial
// decoder for the default build, and a direct byte responder for an 8-bit build.
module tb_fft_uart_frame_sender;
  import fft_uart_pkg::*;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  = 1'b1;
  logic         load = 1'b0;
  logic [255:0] frame = '0;
  logic         tx_active = 1'b0;
  logic         tx_done   = 1'b0;
  logic         tx_serial = 1'b1;
  logic         tx_dv, busy, frame_done, overrun;
  logic [7:0]   tx_byte;
  logic [1:0]   st;

  logic         load2 = 1'b0;
  logic [127:0] frame2 = '0;
  logic [3:0]   cnt2 = 4'd0;
  logic         act2, done2;
  logic         dv2, busy2, fd2, ov2;
  logic [7:0]   byte2;
  logic [1:0]   st2;

  fft_uart_frame_sender dut (
    .i_Clock(clk), .i_Reset(rst), .i_Load(load), .i_Frame(frame),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .o_Busy(busy),
    .o_Frame_Done(frame_done), .o_Overrun(overrun), .o_State(st)
  );

  fft_uart_frame_sender #(.N_POINTS(8), .DATA_WIDTH(8)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Load(load2), .i_Frame(frame2),
    .i_Tx_Active(act2), .i_Tx_Done(done2),
    .o_Tx_DV(dv2), .o_Tx_Byte(byte2), .o_Busy(busy2),
    .o_Frame_Done(fd2), .o_Overrun(ov2), .o_State(st2)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [255:0] f);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++)
          exp_q.push_back(f[(2*k+p)*16 + b*8 +: 8]);
  endtask

  task automatic push_frame2(input logic [127:0] f);
    exp2_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < 2; p++)
        exp2_q.push_back(f[(2*k+p)*8 +: 8]);
  endtask

  // ---------------- behavioural UART transmitter (no reset) ----------------
  int         tx_st = 0, tx_cnt = 0, tx_bit = 0;
  logic [7:0] tx_data = 8'h00;
  always @(posedge clk) begin
    case (tx_st)
      0: begin
        tx_serial <= 1'b1; tx_done <= 1'b0; tx_cnt <= 0; tx_bit <= 0;
        if (tx_dv) begin tx_active <= 1'b1; tx_data <= tx_byte; tx_st <= 1; end
      end
      1: begin
        tx_serial <= 1'b0;
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin tx_cnt <= 0; tx_st <= 2; end
      end
      2: begin
        tx_serial <= tx_data[tx_bit];
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin
          tx_cnt <= 0;
          if (tx_bit < 7) tx_bit <= tx_bit + 1;
          else begin tx_bit <= 0; tx_st <= 3; end
        end
      end
      3: begin
        tx_serial <= 1'b1;
        if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
        else begin tx_done <= 1'b1; tx_active <= 1'b0; tx_cnt <= 0; tx_st <= 4; end
      end
      default: begin tx_done <= 1'b1; tx_st <= 0; end
    endcase
  end

  // Simple responder for the 8-bit build: 5 busy cycles then 2 done cycles.
  always @(posedge clk) begin
    if (dv2) cnt2 <= 4'd7;
    else if (cnt2 != 4'd0) cnt2 <= cnt2 - 4'd1;
  end
  assign act2  = (cnt2 > 4'd2);
  assign done2 = (cnt2 == 4'd1) || (cnt2 == 4'd2);

  // ---------------- serial decoder ----------------
  initial begin
    logic [7:0] rx;
    rx = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_serial == 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = tx_serial;
        end
        repeat (CPB) @(negedge clk);
        check("rx_stop_bit", tx_serial, 1);
        check("rx_have_exp", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", rx, exp_q.pop_front());
      end
    end
  end

  // ---------------- DV handshake monitor ----------------
  int   cyc = 0, dv_total = 0, done_rise_cyc = 0;
  logic gap_valid = 1'b0, prev_dv = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (tx_dv) begin
      dv_total++;
      check("dv_single_cycle", prev_dv, 0);
      check("dv_vs_active", tx_active, 0);
      if (gap_valid) check("dv_gap", cyc - done_rise_cyc, 3);
      gap_valid = 1'b0;
    end
    if (tx_done && !prev_done && busy) begin
      done_rise_cyc = cyc;
      gap_valid     = 1'b1;
    end
    if (!busy) gap_valid = 1'b0;
    prev_dv   = tx_dv;
    prev_done = tx_done;
    cyc++;
  end

  // ---------------- 8-bit build byte capture ----------------
  logic [7:0] cap2[0:31];
  int         cap2_n = 0;
  always @(negedge clk) begin
    if (dv2) begin
      if (cap2_n < 32) cap2[cap2_n] = byte2;
      cap2_n++;
      check("dut2_have_exp", exp2_q.size() != 0, 1);
      if (exp2_q.size() != 0) check("dut2_byte", byte2, exp2_q.pop_front());
    end
  end

  // ---------------- directed sequence ----------------
  logic [255:0] f1, f2, f3;
  logic [127:0] f4;
  logic [7:0]   keep;
  int           n, base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", st, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_dv", tx_dv, 0);
    check("rst_byte", tx_byte, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);

    // Frame 1: re0=1234, im0=ABCD, rest zero; overrun attempt mid-frame.
    f1 = '0;
    f1[15:0]  = 16'h1234;
    f1[31:16] = 16'hABCD;
    push_frame(f1);
    base  = dv_total;
    frame = f1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("load_busy", busy, 1);
    check("load_state", st, ST_ISSUE);
    check("load_no_overrun", overrun, 0);

    n = 0;
    while (dv_total - base < 10 && n < 2000) begin @(negedge clk); n++; end
    check("wait_byte10", n < 2000, 1);
    frame = '1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("overrun_pulse", overrun, 1);
    check("overrun_busy", busy, 1);
    @(negedge clk);
    check("overrun_one_cycle", overrun, 0);

    n = 0;
    while (!frame_done && n < 3000) begin @(negedge clk); n++; end
    check("frame1_done_seen", frame_done, 1);
    check("frame1_dv_count", dv_total - base, 33);
    check("frame1_done_busy", busy, 1);

    // Back-to-back: load in the frame-done cycle is dropped, next one taken.
    for (int i = 0; i < 8; i++) f2[i*32 +: 32] = $urandom;
    frame = f2;
    load  = 1'b1;
    @(negedge clk);
    check("b2b_overrun", overrun, 1);
    check("b2b_done_one_cycle", frame_done, 0);
    check("b2b_idle", st, ST_IDLE);
    check("frame1_drained", exp_q.size(), 0);
    push_frame(f2);
    base = dv_total;
    @(negedge clk);
    load = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_no_overrun", overrun, 0);

    // Reset during byte 5's data bits, then reload 2 cycles later.
    n = 0;
    while (dv_total - base < 6 && n < 2000) begin @(negedge clk); n++; end
    check("wait_byte5", n < 2000, 1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_dv", tx_dv, 0);
    check("midrst_state", st, ST_IDLE);
    check("midrst_inflight", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      keep = exp_q[0];
      exp_q.delete();
      exp_q.push_back(keep);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) f3[i*32 +: 32] = $urandom;
    push_frame(f3);
    base  = dv_total;
    frame = f3;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("reload_busy", busy, 1);
    check("reload_no_overrun", overrun, 0);
    n = 0;
    while (!frame_done && n < 3000) begin @(negedge clk); n++; end
    check("frame3_done_seen", frame_done, 1);
    check("frame3_dv_count", dv_total - base, 33);
    repeat (5) @(negedge clk);
    check("frame3_drained", exp_q.size(), 0);
    check("frame3_idle_busy", busy, 0);

    // 8-bit words: 17 bytes, re3 (word 6) lands at byte index 7.
    for (int i = 0; i < 4; i++) f4[i*32 +: 32] = $urandom;
    f4[6*8 +: 8] = 8'h7F;
    push_frame2(f4);
    frame2 = f4;
    load2  = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    n = 0;
    while (!fd2 && n < 1000) begin @(negedge clk); n++; end
    check("dut2_done_seen", fd2, 1);
    check("dut2_byte_count", cap2_n, 17);
    check("dut2_byte7", cap2[7], 8'h7F);
    check("dut2_drained", exp2_q.size(), 0);
    check("dut2_overrun", ov2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
